// File: rtl/fp_mul_round.sv
// Two-stage IEEE-754 single-precision multiply back end.
// S1 detects special operands, normalizes the mantissa product and forms the
// biased exponent. S2 rounds to nearest-even, range-checks and packs.
// A valid/ready handshake with stall propagation joins the two stages.
module fp_mul_round #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [47:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // pipeline occupancy and load enables
  logic        s1_valid;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;

  // S1 combinational results
  logic        c_sign;
  logic        c_norm;
  logic        c_special;
  logic [31:0] c_spec_res;
  logic [22:0] c_mant;
  logic        c_guard;
  logic        c_sticky;
  logic [9:0]  c_exp;

  // S1 registers
  logic        s1_sign;
  logic        s1_special;
  logic [31:0] s1_spec_res;
  logic [22:0] s1_mant;
  logic        s1_guard;
  logic        s1_sticky;
  logic [9:0]  s1_exp;

  // S2 combinational results
  logic        r_inc;
  logic        r_carry;
  logic [22:0] r_mant;
  logic [9:0]  r_exp;
  logic [31:0] r_result;
  logic [2:0]  r_flags;

  assign out_valid = s2_valid;

  // Stall propagation: S2 frees when empty or drained, S1 when empty or moving on.
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = !rst && s1_load;
  end

  // S1: special-operand decode, normalization and exponent arithmetic
  always_comb begin
    c_sign     = sign_a ^ sign_b;
    c_norm     = prod[47];
    c_special  = (exp_a == 8'hFF) || (exp_b == 8'hFF) ||
                 (exp_a == 8'h00) || (exp_b == 8'h00);
    c_spec_res = {c_sign, 31'b0};
    if (((exp_a == 8'hFF) && (exp_b == 8'h00)) ||
        ((exp_b == 8'hFF) && (exp_a == 8'h00))) begin
      c_spec_res = QNAN;
    end else if ((exp_a == 8'hFF) || (exp_b == 8'hFF)) begin
      // upstream flags a NaN operand through prod[0]
      c_spec_res = prod[0] ? QNAN : {c_sign, 8'hFF, 23'b0};
    end
    if (c_norm) begin
      c_mant   = prod[46:24];
      c_guard  = prod[23];
      c_sticky = |prod[22:0];
    end else begin
      c_mant   = prod[45:23];
      c_guard  = prod[22];
      c_sticky = |prod[21:0];
    end
    // 10-bit two's complement: values below zero and above 255 stay distinguishable
    c_exp = 10'(exp_a) + 10'(exp_b) - 10'(EXP_BIAS) + {9'b0, c_norm};
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign     <= c_sign;
        s1_special  <= c_special;
        s1_spec_res <= c_spec_res;
        s1_mant     <= c_mant;
        s1_guard    <= c_guard;
        s1_sticky   <= c_sticky;
        s1_exp      <= c_exp;
      end
    end
  end

  // S2: round-to-nearest-even, range check and pack
  always_comb begin
    r_inc             = s1_guard & (s1_sticky | s1_mant[0]);
    {r_carry, r_mant} = {1'b0, s1_mant} + {23'b0, r_inc};
    r_exp             = s1_exp + {9'b0, r_carry};
    r_result          = {s1_sign, r_exp[7:0], r_mant};
    r_flags           = {2'b00, s1_guard | s1_sticky};
    if (s1_special) begin
      r_result = s1_spec_res;
      r_flags  = 3'b000;
    end else if ($signed(r_exp) >= 10'sd255) begin
      r_result = {s1_sign, 8'hFF, 23'b0};
      r_flags  = 3'b101;
    end else if ($signed(r_exp) <= 10'sd0) begin
      r_result = {s1_sign, 31'b0};
      r_flags  = 3'b011;
    end
  end

  // S2 register; contents hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= r_result;
        flags  <= r_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round.sv
// Self-checking bench for fp_mul_round: directed corner cases plus randomized
// traffic against an arithmetic reference model and an in-order scoreboard.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [47:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  fp_mul_round #(.EXP_BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [34:0] exp;
    int          c;
  } item_t;

  item_t       sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // operands for the next driven item
  logic        d_sa, d_sb;
  logic [7:0]  d_ea, d_eb;
  logic [47:0] d_p;

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: value-level multiply of the normalized product with RNE rounding.
  function automatic logic [34:0] ref_model(input logic sa, input logic sb_, input logic [7:0] ea,
                                            input logic [7:0] eb, input logic [47:0] p);
    logic        s;
    logic [63:0] pp, m, rem, half;
    int          sh, e;
    logic        inexact;
    s = sa ^ sb_;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {32'h7FC00000, 3'b000};
    if (ea == 255 || eb == 255) return p[0] ? {32'h7FC00000, 3'b000} : {s, 8'hFF, 23'd0, 3'b000};
    if (ea == 0 || eb == 0) return {s, 31'd0, 3'b000};
    pp   = {16'd0, p};
    sh   = (pp >= 64'h8000_0000_0000) ? 24 : 23;
    e    = int'(ea) + int'(eb) - 127 + (sh - 23);
    m    = (pp >> sh) % (64'd1 << 23);
    rem  = pp % (64'd1 << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == (64'd1 << 23)) begin
      m = 0;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (e <= 0) return {s, 31'd0, 3'b011};
    return {s, 8'(e), m[22:0], 2'b00, inexact};
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the scoreboard.
  task automatic step(input logic r, input logic iv, input logic orr, input logic [34:0] e_item,
                      output logic acc);
    logic fo, exp_ov;
    @(negedge clk);
    rst = r; in_valid = iv; out_ready = orr;
    sign_a = d_sa; sign_b = d_sb; exp_a = d_ea; exp_b = d_eb; prod = d_p;
    #1;
    if (r) check("in_ready_rst", 35'(in_ready), 35'(0));
    else   check("in_ready", 35'(in_ready), 35'((sb.size() < 2) || orr));
    exp_ov = (sb.size() > 0) && (cyc >= sb[0].c + 1);
    check("out_valid", 35'(out_valid), 35'(exp_ov));
    if (out_valid && sb.size() > 0) check("result_flags", {result, flags}, sb[0].exp);
    acc = iv && in_ready && !r;
    fo  = out_valid && orr;
    @(posedge clk);
    cyc++;
    if (r) sb.delete();
    else begin
      if (fo && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back('{exp: e_item, c: cyc});
    end
  endtask

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 15))
      0:       return 8'd0;
      1:       return 8'd255;
      2, 3:    return 8'($urandom_range(1, 30));
      4, 5:    return 8'($urandom_range(225, 254));
      default: return 8'($urandom_range(100, 154));
    endcase
  endfunction

  task automatic gen_rand();
    logic [23:0] ma, mb;
    ma = {1'b1, 23'($urandom)};
    mb = {1'b1, 23'($urandom)};
    d_sa = 1'($urandom); d_sb = 1'($urandom);
    d_ea = rand_exp();   d_eb = rand_exp();
    d_p  = 48'(ma) * 48'(mb);
    if ($urandom_range(0, 7) == 0) d_p[22:0] = {1'($urandom), 22'd0};
    if (d_ea == 255 || d_eb == 255) d_p[0] = 1'($urandom);
  endtask

  task automatic send(input logic sa, input logic sb_, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [47:0] p, input logic [34:0] expv);
    logic acc;
    d_sa = sa; d_sb = sb_; d_ea = ea; d_eb = eb; d_p = p;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(1'b0, 1'b1, 1'b1, expv, acc);
    if (!acc) check("send_timeout", 35'(0), 35'(1));
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1'b0, 1'b0, 1'b1, '0, acc);
    check("drain_empty", 35'(sb.size()), 35'(0));
  endtask

  localparam logic [47:0] ONE = 48'h4000_0000_0000;

  initial begin
    logic acc;
    int   idx;
    d_sa = 0; d_sb = 0; d_ea = 0; d_eb = 0; d_p = 0;
    rst = 1; in_valid = 0; out_ready = 0;
    sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0; prod = 0;

    step(1'b1, 1'b0, 1'b0, '0, acc);
    step(1'b1, 1'b0, 1'b0, '0, acc);
    #1;
    check("reset_out_valid", 35'(out_valid), 35'(0));
    check("reset_result_flags", {result, flags}, 35'(0));

    // directed values
    send(0, 0, 127, 127, ONE, {32'h3F800000, 3'b000});
    send(0, 1, 127, 127, 48'h9000_0000_0000, {32'hC0100000, 3'b000});
    send(0, 0, 127, 127, ONE | (48'd1 << 22), {32'h3F800000, 3'b001});
    send(0, 0, 127, 127, ONE | (48'd1 << 23) | (48'd1 << 22), {32'h3F800002, 3'b001});
    send(0, 0, 127, 127, ONE | (48'h7FFFFF << 23) | (48'd1 << 22), {32'h40000000, 3'b001});
    send(0, 0, 254, 254, ONE, {32'h7F800000, 3'b101});
    send(1, 0, 1, 1, ONE, {32'h80000000, 3'b011});
    send(0, 0, 255, 0, ONE, {32'h7FC00000, 3'b000});
    send(1, 0, 0, 255, ONE, {32'h7FC00000, 3'b000});
    send(1, 0, 255, 127, ONE, {32'hFF800000, 3'b000});
    send(0, 0, 255, 127, ONE | 48'd1, {32'h7FC00000, 3'b000});
    send(1, 1, 0, 127, ONE, {32'h00000000, 3'b000});
    send(0, 0, 254, 128, ONE, {32'h7F800000, 3'b101});
    send(0, 0, 254, 127, ONE, {32'h7F000000, 3'b000});
    send(0, 0, 1, 126, ONE, {32'h00000000, 3'b011});
    send(0, 0, 1, 126, 48'h8000_0000_0000, {32'h00800000, 3'b000});
    send(0, 1, 127, 1, ONE, {32'h80800000, 3'b000});
    drain();

    // backpressure: consumer stalls for three cycles while four items stream in
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      gen_rand();
      step(1'b0, 1'b1, (k >= 3), ref_model(d_sa, d_sb, d_ea, d_eb, d_p), acc);
      if (acc) idx++;
      if (k == 2) check("bp_accepts", 35'(idx), 35'(2));
    end
    check("bp_all_sent", 35'(idx), 35'(4));
    drain();

    // reset with two items in flight
    for (int k = 0; k < 2; k++) begin
      gen_rand();
      step(1'b0, 1'b1, 1'b0, ref_model(d_sa, d_sb, d_ea, d_eb, d_p), acc);
    end
    check("rst_inflight", 35'(sb.size()), 35'(2));
    step(1'b1, 1'b0, 1'b0, '0, acc);
    #1;
    check("rst_out_valid", 35'(out_valid), 35'(0));
    check("rst_result_flags", {result, flags}, 35'(0));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, '0, acc);

    // randomized traffic with random backpressure
    for (int k = 0; k < 1500; k++) begin
      gen_rand();
      step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           ref_model(d_sa, d_sb, d_ea, d_eb, d_p), acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
